// File: rtl/uart_cmd_rx.sv
// UART receiver (8N1, or 8E1 when UART_CMD_PARITY_EN is defined) feeding a command
// decoder that turns 'R'/'r' and 'P'/'p'/' ' into fixed-width button pulses.
module uart_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PULSE_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_but_reset,
  output logic       o_but_play_stop
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PW    = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW-1:0]    PULSE_LOAD = PW'(PULSE_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
`ifdef UART_CMD_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t           state, state_next;
  logic [2:0]       rx_sync;
  logic             rx_s;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic [7:0]       rx_data, rx_data_next;
  logic             rx_valid, valid_next;
  logic             frame_err, err_next;
  logic             parity_ok;
  logic             cmd_reset, cmd_play;
  logic [PW-1:0]    rst_cnt, play_cnt;

  assign rx_s = rx_sync[2];

`ifdef UART_CMD_PARITY_EN
  logic par_bit, par_next;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_ok = ~(^{shift, par_bit});
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_sync <= '1;
    end else begin
      rx_sync <= {rx_sync[1:0], i_uart_rx};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    rx_data_next = rx_data;
    valid_next   = 1'b0;
    err_next     = 1'b0;
`ifdef UART_CMD_PARITY_EN
    par_next     = par_bit;
`endif
    unique case (state)
      IDLE: begin
        clk_cnt_next = '0;
        if (!rx_s) begin
          bit_idx_next = '0;
          state_next   = START;
        end
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          shift_next   = {rx_s, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end
`ifdef UART_CMD_PARITY_EN
      PARITY: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          par_next     = rx_s;
          state_next   = STOP;
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          if (rx_s) begin
            state_next = IDLE;
            if (parity_ok) begin
              valid_next   = 1'b1;
              rx_data_next = shift;
            end else begin
              err_next = 1'b1;
            end
          end else begin
            err_next   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decode from the completed shift register so pulses rise together with o_rx_valid.
  always_comb begin
    cmd_reset = 1'b0;
    cmd_play  = 1'b0;
    if (valid_next) begin
      cmd_reset = (shift == 8'h52) || (shift == 8'h72);
      cmd_play  = (shift == 8'h50) || (shift == 8'h70) || (shift == 8'h20);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_CMD_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      clk_cnt   <= clk_cnt_next;
      bit_idx   <= bit_idx_next;
      shift     <= shift_next;
      rx_data   <= rx_data_next;
      rx_valid  <= valid_next;
      frame_err <= err_next;
`ifdef UART_CMD_PARITY_EN
      par_bit   <= par_next;
`endif
    end
  end

  // A repeated command reloads its counter, stretching the pulse with no low gap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rst_cnt  <= '0;
      play_cnt <= '0;
    end else begin
      if (cmd_reset) begin
        rst_cnt <= PULSE_LOAD;
      end else if (rst_cnt != '0) begin
        rst_cnt <= rst_cnt - PW'(1);
      end
      if (cmd_play) begin
        play_cnt <= PULSE_LOAD;
      end else if (play_cnt != '0) begin
        play_cnt <= play_cnt - PW'(1);
      end
    end
  end

  assign o_rx_data       = rx_data;
  assign o_rx_valid      = rx_valid;
  assign o_frame_err     = frame_err;
  assign o_but_reset     = (rst_cnt != '0);
  assign o_but_play_stop = (play_cnt != '0);

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

UART receiver and command decoder that sits directly upstream of the 7-segment LED counter. It drives the counter's reset and play/stop button inputs from a serial console instead of physical buttons. It deserialises 8N1 frames (optionally 8E1) from an asynchronous RX pin and emits the received byte. Recognised command characters are turned into fixed-width active-high button pulses.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `PULSE_CYCLES`, default 16: width in clocks of each button pulse; must be ≥ 1.
- `i_clk`, input, 1: system clock.
- `i_rst_n`, input, 1: synchronous active-low reset.
- `i_uart_rx`, input, 1: asynchronous serial line; idle high.
- `o_rx_data`, output, 8: last received byte; holds until the next valid frame.
- `o_rx_valid`, output, 1: one-cycle strobe; `o_rx_data` is valid in the same cycle.
- `o_frame_err`, output, 1: one-cycle strobe on a bad stop bit (or bad parity, see Configuration).
- `o_but_reset`, output, 1: active-high pulse; connects to the counter's `i_but_reset`.
- `o_but_play_stop`, output, 1: active-high pulse; connects to the counter's `i_but_play_stop`.

## Operation
- **Input synchroniser:** 3-flop shift register on `i_uart_rx`. Reset value is all ones. Only the last stage (`rx_s`) is used.
- **FSM states:** IDLE, START, DATA, PARITY (only when the macro is defined), STOP, WAIT_IDLE.
- **IDLE:** when `rx_s` is 0, clear the bit counter and go to START.
- **START:** count to `CLKS_PER_BIT/2` (integer division), then sample `rx_s`.
  - If 0: go to DATA.
  - If 1: treat as a glitch and return to IDLE. No strobes.
- **DATA:** sample every `CLKS_PER_BIT` clocks, 8 bits LSB first, into a shift register. After bit 7, go to PARITY (when enabled) or STOP.
- **STOP:** sample once after `CLKS_PER_BIT` clocks.
  - If 1: load `o_rx_data`, strobe `o_rx_valid`, decode the command, go to IDLE.
  - If 0: strobe `o_frame_err`, leave `o_rx_data` unchanged, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s` is 1, then go to IDLE. This prevents a stuck-low line from producing repeated frames.
- **Command decode** runs only on a valid frame:
  - 0x52 'R' or 0x72 'r': `o_but_reset` pulse.
  - 0x50 'P', 0x70 'p' or 0x20 ' ': `o_but_play_stop` pulse.
  - Any other byte: `o_rx_valid` only.
- **Pulse generators:** one independent down-counter per output. A command loads the counter with `PULSE_CYCLES`, and the output is high while the counter is nonzero.
  - A repeat command during an active pulse reloads the counter, so the pulse is extended with no low gap. The downstream block therefore sees a single edge, i.e. one toggle.
  - The two generators are independent; both may be high at the same time.
- **Bit-period counter width:** `$clog2(CLKS_PER_BIT)`; it never exceeds `CLKS_PER_BIT-1`.

## Timing
- **Reset:** while `i_rst_n` is 0 on a clock edge:
  - `o_rx_data` = 0x00; `o_rx_valid`, `o_frame_err`, `o_but_reset`, `o_but_play_stop` = 0.
  - FSM goes to IDLE; pulse counters go to 0.
  - This applies mid-frame as well: the partial byte is discarded and no strobe is produced.
- **Input latency:** 3 clocks from `i_uart_rx` to `rx_s`.
- **Stop-bit sample:** occurs `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` clocks after IDLE first sees `rx_s` = 0. With the macro defined, this becomes `+10*CLKS_PER_BIT`.
- **Strobe timing:** `o_rx_valid`/`o_frame_err` are registered and assert on the clock after the stop sample, for exactly 1 cycle.
- **Button pulses:** rise in the same cycle as `o_rx_valid`. Each is high for exactly `PULSE_CYCLES` cycles after its last triggering command.
- **Back-to-back frames:** a start bit immediately after the stop bit is accepted, because IDLE is re-entered in the strobe cycle.
- **No backpressure:** the downstream block must sample every cycle.

## Configuration
- **`UART_CMD_PARITY_EN` undefined:** 8N1; the PARITY state is not built.
- **`UART_CMD_PARITY_EN` defined:** 8E1.
  - PARITY samples one extra bit after DATA.
  - The frame is valid only if the XOR of the 8 data bits and the parity bit is 0.
  - On a parity mismatch with a good stop bit: `o_frame_err` strobes, there is no `o_rx_valid` and no command pulse, and the FSM returns to IDLE.

## Test plan
Bench settings: `CLKS_PER_BIT`=8, `PULSE_CYCLES`=4.
- **Plain byte:** send 0x41 → exactly one `o_rx_valid` with `o_rx_data`=0x41; both button outputs stay 0.
- **Play/stop command:** send 'P' (0x50) → `o_but_play_stop` high for exactly 4 cycles, starting in the `o_rx_valid` cycle. Send 0x20 → same behaviour.
- **Merged reset pulses:** send 'r', then 'R' back-to-back → two `o_rx_valid` strobes. `o_but_reset` pulses twice, because the 2nd frame arrives well after 4 cycles. Repeat with `PULSE_CYCLES`=200 → one merged reset pulse with no low gap.
- **Framing error:** drive the stop bit low on 0x52 → `o_frame_err` 1 cycle; no `o_rx_valid`; `o_rx_data` unchanged; `o_but_reset` stays 0. Hold the line low for 40 cycles, then release → no further strobes.
- **Glitch rejection:** a 2-cycle low glitch on idle → no strobes; FSM back in IDLE.
- **Reset mid-frame:** assert `i_rst_n`=0 for 1 cycle during bit 4 of 0x50 → all outputs 0; no `o_rx_valid`. A following clean 0x50 frame is received normally.
